// File: rtl/mac_drv_pkg.sv
// Shared types and widths for the MAC tile stream driver.
package mac_drv_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FEED    = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        RESULT  = 3'd5
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            last;
    } fifo_entry_t;

    // Product truncated to the accumulator width, matching the tile's wrap.
    function automatic logic [ACC_W-1:0] mac_product(input logic [OP_W-1:0] a,
                                                     input logic [OP_W-1:0] b);
        return ACC_W'(a) * ACC_W'(b);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mac_drv_fifo.sv
// Synchronous FIFO with first-word fall-through read and a registered full flag.
module mac_drv_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = mac_drv_pkg::fifo_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_nxt;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (cnt == '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop)
            cnt_nxt = cnt + CNT_ONE;
        else if (!do_push && do_pop)
            cnt_nxt = cnt - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // full resets high so the upstream sees "not ready" while in reset;
    // it is looked ahead from cnt_nxt so a pop never frees a slot same-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            cnt  <= cnt_nxt;
            full <= (cnt_nxt == FULL_CNT);
        end
    end

endmodule

// File: rtl/mac_stream_driver.sv
// Streams operand bursts into the 8x8 MAC tile and returns each dot product.
// Define MAC_DRV_SHADOW_CHECK_EN to add a shadow accumulator that flags tile mismatches on err.
module mac_stream_driver
    import mac_drv_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [OP_W-1:0]  s_a,
    input  logic [OP_W-1:0]  s_b,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_acc,
    output logic [CNT_W-1:0] m_count,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic             mac_ena,
    output logic             mac_rst_n,
    input  logic [OP_W-1:0]  mac_acc_lo,
    input  logic [OP_W-1:0]  mac_acc_hi,
    output logic             busy,
    output logic             err
);

    localparam logic [2:0] WAIT_INIT = 3'(LAT - 1);

    state_e          state, state_nxt;
    fifo_entry_t     push_entry, head;
    logic            fifo_full, fifo_empty;
    logic            pop, clr_acc;
    logic [2:0]      wait_cnt;
    logic [OP_W-1:0] a_hold, b_hold;

    assign push_entry = '{a: s_a, b: s_b, last: s_last};
    assign s_ready    = !fifo_full;

    mac_drv_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = CLEAR;
            CLEAR:   state_nxt = FEED;
            FEED:    if (!fifo_empty && head.last) state_nxt = WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESULT;
            RESULT:  if (m_ready) state_nxt = fifo_empty ? IDLE : CLEAR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        clr_acc = 1'b0;
        m_valid = 1'b0;
        case (state)
            CLEAR:   clr_acc = 1'b1;
            FEED:    pop     = !fifo_empty;
            RESULT:  m_valid = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    // The pop cycle itself is the accumulate cycle; operands fall through from the FIFO head.
    assign mac_ena = pop;
    assign mac_a   = pop ? head.a : a_hold;
    assign mac_b   = pop ? head.b : b_hold;

    // Looked ahead from state_nxt so the clear lines up exactly with the CLEAR cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mac_rst_n <= 1'b0;
        else
            mac_rst_n <= (state_nxt != CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_hold <= '0;
            b_hold <= '0;
        end else if (pop) begin
            a_hold <= head.a;
            b_hold <= head.b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_count <= '0;
        else if (clr_acc)
            m_count <= '0;
        else if (pop)
            m_count <= sat_inc(m_count);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (pop && head.last)
            wait_cnt <= WAIT_INIT;
        else if (state == WAIT && wait_cnt != 3'd0)
            wait_cnt <= wait_cnt - 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_acc <= '0;
        else if (state == CAPTURE)
            m_acc <= {mac_acc_hi, mac_acc_lo};
    end

`ifdef MAC_DRV_SHADOW_CHECK_EN
    logic [ACC_W-1:0] shadow;
    logic             err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            err_q  <= 1'b0;
        end else begin
            if (clr_acc)
                shadow <= '0;
            else if (pop)
                shadow <= shadow + mac_product(head.a, head.b);
            if (state == CAPTURE && shadow != {mac_acc_hi, mac_acc_lo})
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_stream_driver.sv
// Directed bench for mac_stream_driver with a behavioural MAC tile and a result scoreboard.
module tb_mac_stream_driver;

`ifdef TB_LAT3
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk, rst_n;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_a, s_b;
    logic        m_valid, m_ready;
    logic [15:0] m_acc;
    logic [7:0]  m_count;
    logic [7:0]  mac_a, mac_b, mac_acc_lo, mac_acc_hi;
    logic        mac_ena, mac_rst_n, busy, err;

    mac_stream_driver #(.LAT(LAT), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_acc(m_acc), .m_count(m_count),
        .mac_a(mac_a), .mac_b(mac_b), .mac_ena(mac_ena), .mac_rst_n(mac_rst_n),
        .mac_acc_lo(mac_acc_lo), .mac_acc_hi(mac_acc_hi),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tile: accumulator plus LAT-1 output delay stages, async clear.
    logic [15:0] mpipe [LAT];
    logic        corrupt = 1'b0;

    always @(posedge clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            for (int i = 0; i < LAT; i++) mpipe[i] <= 16'h0;
        end else begin
            if (mac_ena) mpipe[0] <= mpipe[0] + 16'(mac_a) * 16'(mac_b);
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mac_acc_lo = mpipe[LAT-1][7:0];
    assign mac_acc_hi = mpipe[LAT-1][15:8] + {7'd0, corrupt};

    // Event monitor
    int   cyc = 0;
    int   ena_cnt, ena_run, ena_max, rst_low, last_ena, vrise;
    logic mv_prev = 1'b0;
    bit   mon_clr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_clr) begin
            ena_cnt = 0; ena_run = 0; ena_max = 0; rst_low = 0;
        end else begin
            if (mac_ena) begin
                ena_cnt++; ena_run++; last_ena = cyc;
                if (ena_run > ena_max) ena_max = ena_run;
            end else begin
                ena_run = 0;
            end
            if (rst_n && !mac_rst_n) rst_low++;
        end
        if (m_valid && !mv_prev) vrise = cyc;
        mv_prev = m_valid;
    end

    // Scoreboard
    typedef struct { logic [15:0] acc; logic [7:0] cnt; } exp_t;
    exp_t        sb [$];
    logic [15:0] exp_acc = 16'h0;
    logic [7:0]  exp_cnt = 8'h0;
    logic        err_exp = 1'b0;
    int          n_total = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model_push(input logic [7:0] a, input logic [7:0] b, input logic last);
        exp_t e;
        exp_acc = exp_acc + 16'(a) * 16'(b);
        if (exp_cnt != 8'hFF) exp_cnt++;
        if (last) begin
            e.acc = exp_acc + (corrupt ? 16'h0100 : 16'h0000);
            e.cnt = exp_cnt;
            sb.push_back(e);
            exp_acc = 16'h0;
            exp_cnt = 8'h0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n = 0;
        s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
        while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("push_timeout", 32'd0, 32'd1);
        else model_push(a, b, last);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!m_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd1);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        wait_valid(tag);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_m_acc"},   32'(m_acc),   32'(e.acc));
            chk({tag, "_m_count"}, 32'(m_count), 32'(e.cnt));
        end
        chk({tag, "_err"}, 32'(err), 32'(err_exp));
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk({tag, "_m_valid_drop"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        int nb;
        logic acc_now;
        rst_n = 1'b1; s_valid = 1'b0; s_a = 8'h0; s_b = 8'h0; s_last = 1'b0; m_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_ready",   32'(s_ready),   32'd0);
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        chk("rst_mac_ena",   32'(mac_ena),   32'd0);
        chk("rst_mac_rst_n", 32'(mac_rst_n), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_m_acc",     32'(m_acc),     32'd0);
        chk("rst_m_count",   32'(m_count),   32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_s_ready",   32'(s_ready),   32'd1);
        chk("post_rst_mac_rst_n", 32'(mac_rst_n), 32'd1);

        // Basic burst, back-to-back pops
        clear_mon();
        push_pair(8'd3, 8'd4, 1'b0);
        push_pair(8'd2, 8'd5, 1'b0);
        push_pair(8'd10, 8'd10, 1'b1);
        collect("basic");
        chk("basic_ena_cnt", 32'(ena_cnt), 32'd3);
        chk("basic_ena_run", 32'(ena_max), 32'd3);
        chk("basic_latency", 32'(vrise - last_ena), 32'(LAT + 2));
        chk("basic_clr_cnt", 32'(rst_low), 32'd1);

        // Single pair and 16-bit wrap
        clear_mon();
        push_pair(8'd255, 8'd255, 1'b1);
        collect("single");
        chk("single_clr_cnt", 32'(rst_low), 32'd1);
        clear_mon();
        push_pair(8'd255, 8'd255, 1'b0);
        push_pair(8'd255, 8'd255, 1'b1);
        collect("wrap");
        chk("wrap_clr_cnt", 32'(rst_low), 32'd1);

        // Result backpressure while the next burst queues up
        push_pair(8'd2, 8'd3, 1'b1);
        wait_valid("bp_a");
        clear_mon();
        nb = 0;
        for (int c = 0; c < 10; c++) begin
            s_valid = (nb < 6); s_a = 8'(nb + 1); s_b = 8'(nb + 1); s_last = (nb == 5);
            acc_now = s_valid && s_ready;
            if (acc_now) model_push(s_a, s_b, s_last);
            @(posedge clk); #1;
            if (acc_now) nb++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("bp_accepted", 32'(nb), 32'd4);
        chk("bp_s_ready",  32'(s_ready), 32'd0);
        chk("bp_hold_valid", 32'(m_valid), 32'd1);
        if (sb.size() > 0) chk("bp_hold_acc", 32'(m_acc), 32'(sb[0].acc));
        chk("bp_hold_count", 32'(m_count), 32'd1);
        chk("bp_no_clear", 32'(rst_low), 32'd0);
        collect("bp_a");
        push_pair(8'd5, 8'd5, 1'b0);
        push_pair(8'd6, 8'd6, 1'b1);
        collect("bp_b");
        chk("bp_clr_cnt", 32'(rst_low), 32'd1);

        // Input bubbles: operands hold while mac_ena is low
        clear_mon();
        push_pair(8'd1, 8'd1, 1'b0);
        idle(3);
        push_pair(8'd2, 8'd2, 1'b0);
        idle(1);
        chk("bub_ena_low", 32'(mac_ena), 32'd0);
        chk("bub_hold_a",  32'(mac_a),   32'd2);
        chk("bub_hold_b",  32'(mac_b),   32'd2);
        idle(2);
        push_pair(8'd3, 8'd3, 1'b1);
        collect("bubble");
        chk("bub_ena_cnt", 32'(ena_cnt), 32'd3);
        chk("bub_ena_run", 32'(ena_max), 32'd1);

        // Asynchronous reset mid-burst
        push_pair(8'd1, 8'd2, 1'b0);
        push_pair(8'd3, 8'd4, 1'b0);
        idle(3);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_acc = 16'h0; exp_cnt = 8'h0; err_exp = 1'b0;
        chk("mid_s_ready",   32'(s_ready),   32'd0);
        chk("mid_m_valid",   32'(m_valid),   32'd0);
        chk("mid_mac_ena",   32'(mac_ena),   32'd0);
        chk("mid_mac_rst_n", 32'(mac_rst_n), 32'd0);
        chk("mid_mac_a",     32'(mac_a),     32'd0);
        chk("mid_mac_b",     32'(mac_b),     32'd0);
        chk("mid_busy_rst",  32'(busy),      32'd0);
        chk("mid_m_count",   32'(m_count),   32'd0);
        chk("mid_m_acc",     32'(m_acc),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_mac_rst_n", 32'(mac_rst_n), 32'd0);
        @(posedge clk); #1;
        chk("mid_clk_mac_rst_n", 32'(mac_rst_n), 32'd1);
        chk("mid_clk_s_ready",   32'(s_ready),   32'd1);
        push_pair(8'd6, 8'd7, 1'b1);
        collect("after_rst");

`ifdef MAC_DRV_SHADOW_CHECK_EN
        corrupt = 1'b1;
        push_pair(8'd1, 8'd1, 1'b1);
        err_exp = 1'b1;
        collect("shadow_bad");
        corrupt = 1'b0;
        push_pair(8'd2, 8'd2, 1'b1);
        collect("shadow_sticky");
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
